// File: rtl/if_pkg.sv
//------------------------------------------------------------------------------
// Package    : if_pkg
// Description: Shared FSM state encoding and default constants for the
//              instruction-fetch / IF-ID pipeline stage.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package if_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,  // idle or first cycle of a fetch
    S_WAIT    = 2'd1,  // imem response pending
    S_DISCARD = 2'd2   // squashed fetch still in flight, drop its response
  } fetch_state_t;

  localparam int unsigned c_PC_STEP   = 4;
  localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;

endpackage : if_pkg

`default_nettype wire

// File: rtl/if_fetch_fsm.sv
//------------------------------------------------------------------------------
// Module     : if_fetch_fsm
// Description: Fetch sequencer. Tracks the single outstanding imem fetch,
//              decides when a response may be accepted and generates the
//              PC register write-enable.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_fetch_fsm
  import if_pkg::*;
(
  input  logic         clk,
  input  logic         rst,         // synchronous, active-low
  input  logic         imem_valid,
  input  logic         stall,
  input  logic         flush,
  output fetch_state_t state,
  output logic         pc_write,
  output logic         fetch_busy
);

  fetch_state_t r_state;

  // State register and next-state selection (reset > flush > stall > normal)
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else if (flush) begin
      // A fetch still in flight after the redirect must have its response dropped
      if (imem_valid || (r_state == S_FETCH)) r_state <= S_FETCH;
      else                                    r_state <= S_DISCARD;
    end else if (stall) begin
      // A squashed response can still be retired while the pipe is stalled
      if ((r_state == S_DISCARD) && imem_valid) r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH,
        S_WAIT:    r_state <= imem_valid ? S_FETCH : S_WAIT;
        S_DISCARD: r_state <= imem_valid ? S_FETCH : S_DISCARD;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  // PC advances on an accepted fetch or on a redirect; held otherwise
  always_comb begin
    pc_write = 1'b0;
    if (!rst) begin
      pc_write = 1'b0;
    end else if (flush) begin
      pc_write = 1'b1;
    end else if (stall) begin
      pc_write = 1'b0;
    end else if ((r_state == S_FETCH) || (r_state == S_WAIT)) begin
      pc_write = imem_valid;
    end
  end

  assign state      = r_state;
  assign fetch_busy = (r_state != S_FETCH);

endmodule : if_fetch_fsm

`default_nettype wire

// File: rtl/if_id_stage.sv
//------------------------------------------------------------------------------
// Module     : if_id_stage
// Description: Fetch-side pipeline stage. Latches PC and imem response into
//              the IF/ID register, inserting bubbles on memory wait and flush.
//              Optional feature macro: IF_ID_PERF_EN (adds perf_bubbles
//              saturating bubble counter output).
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_id_stage
  import if_pkg::*;
#(
  parameter int unsigned         DATA_W    = 32,
  parameter int unsigned         PC_STEP   = c_PC_STEP,
  parameter logic [DATA_W-1:0]   NOP_INSTR = c_NOP_INSTR[DATA_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,         // synchronous, active-low
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_valid,
  input  logic              stall,
  input  logic              flush,
  output logic              pc_write,
  output logic [DATA_W-1:0] if_id_pc,
  output logic [DATA_W-1:0] if_id_pc4,
  output logic [DATA_W-1:0] if_id_instr,
  output logic              if_id_valid,
`ifdef IF_ID_PERF_EN
  output logic [31:0]       perf_bubbles,
`endif
  output logic              fetch_busy
);

  fetch_state_t      w_state;
  logic              w_accepting;    // FETCH or WAIT: a response may be taken
  logic              w_capture;      // IF/ID loads a real instruction
  logic              w_wait_bubble;  // IF/ID loads a bubble because imem is slow
  logic [DATA_W-1:0] w_pc4;

  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_pc4;
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;

  if_fetch_fsm u_fsm (
    .clk        (clk),
    .rst        (rst),
    .imem_valid (imem_valid),
    .stall      (stall),
    .flush      (flush),
    .state      (w_state),
    .pc_write   (pc_write),
    .fetch_busy (fetch_busy)
  );

  // Wraps modulo 2^DATA_W; carry out is intentionally discarded
  assign w_pc4         = pc_in + DATA_W'(PC_STEP);
  assign w_accepting   = (w_state == S_FETCH) || (w_state == S_WAIT);
  assign w_capture     = !flush && !stall && w_accepting &&  imem_valid;
  assign w_wait_bubble = !flush && !stall && w_accepting && !imem_valid;

  // IF/ID pipeline register: reset > flush > stall/discard hold > capture/bubble
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc    <= '0;
      r_pc4   <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_pc    <= '0;
      r_pc4   <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_pc    <= pc_in;
      r_pc4   <= w_pc4;
      r_instr <= imem_rdata;
      r_valid <= 1'b1;
    end else if (w_wait_bubble) begin
      // PC fields are left as-is; only the instruction is killed
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end
  end

  assign if_id_pc    = r_pc;
  assign if_id_pc4   = r_pc4;
  assign if_id_instr = r_instr;
  assign if_id_valid = r_valid;

`ifdef IF_ID_PERF_EN
  logic [31:0] r_perf_bubbles;

  // Count cycles where IF/ID loads a bubble; saturate at all-ones
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_bubbles <= '0;
    end else if ((flush || w_wait_bubble) && (r_perf_bubbles != 32'hFFFF_FFFF)) begin
      r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end
  end

  assign perf_bubbles = r_perf_bubbles;
`endif

endmodule : if_id_stage

`default_nettype wire

// File: tb/tb_if_id_stage.sv
//------------------------------------------------------------------------------
// Module     : tb_if_id_stage
// Description: Directed self-checking bench for if_id_stage.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        flush;
  logic        pc_write;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fetch_busy;

  int total;
  int bad;

  if_id_stage dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .stall       (stall),
    .flush       (flush),
    .pc_write    (pc_write),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .fetch_busy  (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check comb pc_write, then clock and settle
  task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] rd,
                      input logic v, input logic st, input logic fl, input logic exp_pw);
    pc_in      = pc;
    imem_rdata = rd;
    imem_valid = v;
    stall      = st;
    flush      = fl;
    #1;
    chk({tag, ".pc_write"}, {31'd0, pc_write}, {31'd0, exp_pw});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] epc, input logic [31:0] epc4,
                          input logic [31:0] einstr, input logic evalid, input logic ebusy);
    chk({tag, ".pc"},    if_id_pc,    epc);
    chk({tag, ".pc4"},   if_id_pc4,   epc4);
    chk({tag, ".instr"}, if_id_instr, einstr);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, evalid});
    chk({tag, ".busy"},  {31'd0, fetch_busy},  {31'd0, ebusy});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;

    // Reset held for two cycles
    step("rst0", 32'h0000_0050, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rst1", 32'h0000_0050, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;

    // Back-to-back single-cycle fetches
    step("seq0", 32'h0000_0100, 32'h1111_0001, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_ifid("seq0", 32'h100, 32'h104, 32'h1111_0001, 1'b1, 1'b0);
    step("seq1", 32'h0000_0100, 32'h1111_0002, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_ifid("seq1", 32'h100, 32'h104, 32'h1111_0002, 1'b1, 1'b0);
    step("seq2", 32'h0000_0100, 32'h1111_0003, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_ifid("seq2", 32'h100, 32'h104, 32'h1111_0003, 1'b1, 1'b0);

    // Multi-cycle memory: two wait bubbles, then the response
    step("wait0", 32'h0000_0200, 32'hXXXX_XXXX, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ifid("wait0", 32'h100, 32'h104, 32'h0, 1'b0, 1'b1);
    step("wait1", 32'h0000_0200, 32'hXXXX_XXXX, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ifid("wait1", 32'h100, 32'h104, 32'h0, 1'b0, 1'b1);
    step("wait2", 32'h0000_0200, 32'h8C22_0004, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_ifid("wait2", 32'h200, 32'h204, 32'h8C22_0004, 1'b1, 1'b0);

    // Stall holds IF/ID and PC even with a valid response present
    step("pre_stall", 32'h0000_0300, 32'hAAAA_0001, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_ifid("pre_stall", 32'h300, 32'h304, 32'hAAAA_0001, 1'b1, 1'b0);
    step("stall0", 32'h0000_0304, 32'hBBBB_0002, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_ifid("stall0", 32'h300, 32'h304, 32'hAAAA_0001, 1'b1, 1'b0);
    step("stall1", 32'h0000_0304, 32'hBBBB_0002, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_ifid("stall1", 32'h300, 32'h304, 32'hAAAA_0001, 1'b1, 1'b0);
    step("unstall", 32'h0000_0304, 32'hBBBB_0002, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_ifid("unstall", 32'h304, 32'h308, 32'hBBBB_0002, 1'b1, 1'b0);

    // Flush while waiting: bubble, then drop the stale response
    step("fw_wait", 32'h0000_0400, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ifid("fw_wait", 32'h304, 32'h308, 32'h0, 1'b0, 1'b1);
    step("fw_flush", 32'h0000_0400, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_ifid("fw_flush", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    step("fw_drop", 32'h0000_0500, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ifid("fw_drop", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("fw_next", 32'h0000_0500, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_ifid("fw_next", 32'h500, 32'h504, 32'h1234_5678, 1'b1, 1'b0);

    // Flush and stall together: flush wins
    step("fs", 32'h0000_0504, 32'h5555_5555, 1'b1, 1'b1, 1'b1, 1'b1);
    chk_ifid("fs", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Discarded response retired while stalled
    step("ds_wait", 32'h0000_0600, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ifid("ds_wait", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    step("ds_flush", 32'h0000_0600, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_ifid("ds_flush", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    step("ds_stall", 32'h0000_0700, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_ifid("ds_stall", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // PC increment wraps
    step("wrap", 32'hFFFF_FFFC, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_ifid("wrap", 32'hFFFF_FFFC, 32'h0, 32'h0000_0013, 1'b1, 1'b0);

    // Reset while discarding abandons the fetch
    step("rd_wait", 32'h0000_0800, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rd_flush", 32'h0000_0800, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_ifid("rd_flush", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    rst = 1'b0;
    step("rd_rst", 32'h0000_0800, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ifid("rd_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    step("rd_after", 32'h0000_0900, 32'h0000_0093, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_ifid("rd_after", 32'h900, 32'h904, 32'h0000_0093, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_if_id_stage

`default_nettype wire

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch-side pipeline stage directly downstream of the PC register.
- Takes the current PC and the instruction-memory response, and produces the IF/ID pipeline register contents for decode.
- Drives the PC register write-enable (pc_write), so the PC advances only when a fetch is accepted or redirected.
- Handles hazard stalls, branch/jump flushes and multi-cycle instruction-memory latency; at most one fetch is outstanding.

Parameters:
DATA_W, 32, width of PC and instruction words
PC_STEP, 4, byte increment from PC to sequential next PC
NOP_INSTR, 32'h00000000, instruction word inserted on a bubble

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low (0 = reset)
pc_in  in  DATA_W  current PC (PC register output)
imem_rdata  in  DATA_W  instruction word for the oldest outstanding fetch
imem_valid  in  1  imem_rdata valid this cycle
stall  in  1  hazard unit: hold IF/ID and PC
flush  in  1  taken branch/jump: kill IF/ID, PC loads redirect target
pc_write  out  1  write-enable to PC register (combinational)
if_id_pc  out  DATA_W  PC of latched instruction
if_id_pc4  out  DATA_W  if_id_pc + PC_STEP
if_id_instr  out  DATA_W  latched instruction
if_id_valid  out  1  IF/ID holds a real instruction
fetch_busy  out  1  1 when state != FETCH

Behaviour:
- All registers update on posedge clk.
- Priority: rst low > flush > stall > normal.
- Reset (rst=0): if_id_pc=0, if_id_pc4=0, if_id_instr=NOP_INSTR, if_id_valid=0, state=FETCH. pc_write=0 while rst=0.
- FSM states:
  - FETCH: idle or first cycle of a fetch.
  - WAIT: imem response pending.
  - DISCARD: squashed fetch still in flight; its response must be dropped.
- FETCH/WAIT, imem_valid=1, stall=0, flush=0:
  - Capture pc_in, pc_in+PC_STEP, imem_rdata; if_id_valid=1.
  - pc_write=1; next state FETCH. Latency 1 cycle from response to IF/ID.
- FETCH/WAIT, imem_valid=0, stall=0, flush=0:
  - Insert bubble: if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc/pc4 unchanged.
  - pc_write=0; next state WAIT.
- stall=1, flush=0, any state:
  - IF/ID holds all values; pc_write=0.
  - An imem_valid response is not captured; imem re-presents it because the PC is unchanged.
  - State: FETCH stays FETCH, WAIT stays WAIT; DISCARD goes to FETCH if imem_valid=1, else stays DISCARD.
- flush=1 (overrides stall):
  - IF/ID becomes a bubble: instr=NOP_INSTR, valid=0, pc=0, pc4=0.
  - pc_write=1.
  - Next state: if imem_valid=1 or state=FETCH, go to FETCH; otherwise (fetch in flight) go to DISCARD.
- DISCARD, flush=0:
  - pc_write=0; IF/ID keeps the bubble.
  - On imem_valid=1, drop imem_rdata and go to FETCH.
- PC arithmetic: if_id_pc4 = pc_in + PC_STEP modulo 2^DATA_W; 32'hFFFFFFFC gives 0, no carry out.
- A reset asserted mid-WAIT or mid-DISCARD abandons the outstanding fetch. The memory side is reset by the same rst.

Optional Feature:
IF_ID_PERF_EN
- Defined:
  - Adds output perf_bubbles [31:0], a saturating counter; reset value 0.
  - Increments once per cycle in which IF/ID loads a bubble (wait or flush). A stall hold does not count.
  - Saturates at 32'hFFFFFFFF.
- Undefined: the port and counter are absent; the rest of the behaviour is identical.

Decomposition:
- Package if_pkg:
  - FSM state encoding: FETCH=2'd0, WAIT=2'd1, DISCARD=2'd2.
  - NOP_INSTR and PC_STEP defaults.
- Sub-module if_fetch_fsm: state register, next-state logic, pc_write/fetch_busy generation.
- Top level: IF/ID datapath registers and optional perf counter.

Test Plan:
- Reset then release; pc_in=0x100, imem_valid=1 for 3 cycles → IF/ID pc 0x100, pc4 0x104, valid=1 each cycle; pc_write=1 each cycle.
- pc_in=0x200, imem_valid=0 for 2 cycles then 1 with rdata=0x8C220004 → valid=0 and NOP for 2 cycles, fetch_busy=1; then instr=0x8C220004, pc=0x200, pc_write=1 only in the last cycle.
- stall=1 for 2 cycles with imem_valid=1 after IF/ID holds pc=0x300 → IF/ID unchanged, pc_write=0; on stall release, the new instruction is captured.
- flush=1 while in WAIT (imem_valid=0) → bubble with pc=0, pc_write=1, state DISCARD; next imem_valid=1 with rdata=0xDEADBEEF is dropped (valid stays 0), then FETCH.
- flush=1 and stall=1 in the same cycle → flush wins: bubble and pc_write=1.
- pc_in=0xFFFFFFFC, imem_valid=1 → if_id_pc4=0x00000000; rst=0 during DISCARD → all outputs at reset values, state FETCH next cycle.
